// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types for the RSA timing probe
package rsa_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT, S_DRAIN, S_DONE} probe_state_e;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] m;
    logic [DEF_CNT_W-1:0] cycles;
    logic                 match;
    logic                 timeout;
  } res_rec_t;
endpackage

// File: rtl/rsa_cycle_counter.sv
// rsa_cycle_counter: clearable up-counter that saturates at LIMIT
module rsa_cycle_counter #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             hit_limit
);
  assign hit_limit = count == LIMIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en && !hit_limit) count <= count + 1'b1;
endmodule

// File: rtl/rsa_timing_probe.sv
// rsa_timing_probe: drives the RSA core over a plaintext sweep and reports per-run latency
module rsa_timing_probe
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_first,
  input  logic [WIDTH-1:0] num_msgs,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_q,
  output logic [WIDTH-1:0] rsa_m,
  output logic             rsa_KeyGenStart,
  input  logic [WIDTH-1:0] rsa_m_decrypted,
  input  logic             rsa_finish,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_m,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_match,
  output logic             res_timeout,
  output logic             busy,
  output logic             done,
  output logic             error
);
  probe_state_e state_q, state_d;
  logic [WIDTH-1:0] remaining;
  logic [CNT_W-1:0] count;
  logic hit_limit, last_run;
  // The count runs through LAUNCH, so in cycle LAUNCH+k it reads exactly k.
  rsa_cycle_counter #(.CNT_W(CNT_W), .LIMIT(CNT_W'(TIMEOUT))) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!(state_q == S_LAUNCH || state_q == S_WAIT)),
    .en(state_q == S_LAUNCH || state_q == S_WAIT),
    .count(count),
    .hit_limit(hit_limit)
  );
  assign last_run = res_timeout || remaining == WIDTH'(1);
  assign rsa_KeyGenStart = state_q == S_LAUNCH;
  assign res_valid = state_q == S_REPORT;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_msgs != '0) ? S_DRAIN : S_DONE;
      S_DRAIN:  if (!rsa_finish) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (rsa_finish || hit_limit) state_d = S_REPORT;
      S_REPORT: if (res_ready) state_d = last_run ? S_DONE : S_DRAIN;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsa_p <= '0;
      rsa_q <= '0;
      rsa_m <= '0;
      remaining <= '0;
      res_m <= '0;
      res_cycles <= '0;
      res_match <= 1'b0;
      res_timeout <= 1'b0;
      error <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        error <= 1'b0;
        if (num_msgs != '0) begin
          rsa_p <= p_in;
          rsa_q <= q_in;
          rsa_m <= m_first;
          remaining <= num_msgs;
        end
      end
      if (state_q == S_WAIT && (rsa_finish || hit_limit)) begin
        res_m <= rsa_m;
        res_cycles <= count;
        res_match <= rsa_finish && rsa_m_decrypted == rsa_m;
        res_timeout <= !rsa_finish;
        if (!rsa_finish) error <= 1'b1;
      end
      if (state_q == S_REPORT && res_ready && !last_run) begin
        rsa_m <= rsa_m + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
endmodule

// File: tb/tb_rsa_timing_probe.sv
// tb_rsa_timing_probe: sweeps the probe against a latency-programmable RSA stub
module tb_rsa_timing_probe;
  import rsa_pkg::*;
  localparam int W = 8;
  localparam int CW = 16;
  localparam int TMO_T = 100;
  typedef struct {
    logic [W-1:0] p, q, mf, n;
    int mode, latc, flip, hold, exp_recs, exp_cyc0;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, start_t = 1'b0, res_ready = 1'b1;
  logic [W-1:0] p_in = '0, q_in = '0, m_first = '0, num_msgs = '0;
  logic [W-1:0] rsa_p, rsa_q, rsa_m, rsa_m_dec;
  logic rsa_kgs, rsa_finish, res_valid, res_match, res_timeout, busy, done, error;
  logic [W-1:0] res_m;
  logic [CW-1:0] res_cycles;
  logic [W-1:0] rsa_p_t, rsa_q_t, rsa_m_t, res_m_t;
  logic rsa_kgs_t, res_valid_t, res_match_t, res_timeout_t, busy_t, done_t, error_t;
  logic [CW-1:0] res_cycles_t;

  rsa_timing_probe dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p_in(p_in), .q_in(q_in),
    .m_first(m_first), .num_msgs(num_msgs), .rsa_p(rsa_p), .rsa_q(rsa_q),
    .rsa_m(rsa_m), .rsa_KeyGenStart(rsa_kgs), .rsa_m_decrypted(rsa_m_dec),
    .rsa_finish(rsa_finish), .res_valid(res_valid), .res_ready(res_ready),
    .res_m(res_m), .res_cycles(res_cycles), .res_match(res_match),
    .res_timeout(res_timeout), .busy(busy), .done(done), .error(error)
  );

  // Second probe with a short budget wired to a core that never finishes.
  rsa_timing_probe #(.TIMEOUT(TMO_T)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .p_in(p_in), .q_in(q_in),
    .m_first(m_first), .num_msgs(num_msgs), .rsa_p(rsa_p_t), .rsa_q(rsa_q_t),
    .rsa_m(rsa_m_t), .rsa_KeyGenStart(rsa_kgs_t), .rsa_m_decrypted('0),
    .rsa_finish(1'b0), .res_valid(res_valid_t), .res_ready(res_ready),
    .res_m(res_m_t), .res_cycles(res_cycles_t), .res_match(res_match_t),
    .res_timeout(res_timeout_t), .busy(busy_t), .done(done_t), .error(error_t)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RSA stub: finish rises LAT cycles after KeyGenStart, held HOLD cycles.
  int mode = 0, latc = 1, flip = -1, hold = 1, base = 0;
  int age = 0, s_lat = 0, run_idx = 0;
  bit pend = 1'b0;
  logic [W-1:0] s_mdec = '0;
  function automatic int lat_of(logic [W-1:0] m);
    return (mode == 1) ? 20 + int'(m) : latc;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= 1'b0;
      age <= 0;
    end else if (rsa_kgs) begin
      pend <= 1'b1;
      age <= 1;
      s_lat <= lat_of(rsa_m);
      s_mdec <= (run_idx - base == flip) ? rsa_m ^ 8'd1 : rsa_m;
      run_idx <= run_idx + 1;
    end else if (pend) age <= age + 1;
  assign rsa_finish = pend && age >= s_lat && age < s_lat + hold;
  assign rsa_m_dec = s_mdec;

  res_rec_t got[$], got_t[$];
  int kgs_at[$];
  int kgs_t_cnt = 0, done_cnt = 0, done_t_cnt = 0, stale = 0;
  always @(negedge clk) begin
    if (res_valid && res_ready) got.push_back('{m: res_m, cycles: res_cycles, match: res_match, timeout: res_timeout});
    if (res_valid_t && res_ready) got_t.push_back('{m: res_m_t, cycles: res_cycles_t, match: res_match_t, timeout: res_timeout_t});
    if (rsa_kgs) kgs_at.push_back(cyc);
    if (rsa_kgs && rsa_finish) stale++;
    if (rsa_kgs_t) kgs_t_cnt++;
    if (done) done_cnt++;
    if (done_t) done_t_cnt++;
  end

  int n_chk = 0, n_fail = 0, start_cyc = 0;
  task automatic chk(input string nm, input longint got_v, input longint exp_v);
    n_chk++;
    if (got_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got_v, exp_v);
    end
  endtask

  task automatic go(input logic [W-1:0] p, q, mf, n, input bit tgt);
    @(negedge clk);
    p_in = p;
    q_in = q;
    m_first = mf;
    num_msgs = n;
    if (tgt) start_t = 1'b1;
    else start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic wait_done(input bit tgt, input int d0, input string nm);
    int i;
    for (i = 0; i < 30000; i++) begin
      @(posedge clk);
      #1;
      if ((tgt ? done_t_cnt : done_cnt) != d0) break;
    end
    chk(nm, longint'(i < 30000), 1);
  endtask

  vec_t vt[9];
  initial begin
    int rb, kb, d0, lprev, gap;
    logic [W-1:0] m_e;
    res_rec_t r;
    logic [25:0] snap;
    vt[0] = '{8'd11, 8'd13, 8'd5, 8'd1, 0, 37, -1, 1, 1, 37};
    vt[1] = '{8'd3, 8'd5, 8'd254, 8'd4, 1, 0, -1, 1, 4, 274};
    vt[2] = '{8'd7, 8'd11, 8'd40, 8'd3, 0, 15, 1, 1, 3, 15};
    vt[3] = '{8'd5, 8'd7, 8'd9, 8'd2, 0, 1, -1, 1, 2, 1};
    vt[4] = '{8'd2, 8'd3, 8'd100, 8'd3, 0, 12, -1, 3, 3, 12};
    for (int v = 5; v < 9; v++) begin
      vt[v].p = W'($urandom);
      vt[v].q = W'($urandom);
      vt[v].mf = W'($urandom);
      vt[v].n = W'($urandom_range(1, 5));
      vt[v].mode = 0;
      vt[v].latc = int'($urandom_range(1, 60));
      vt[v].flip = int'($urandom_range(0, 32'(vt[v].n)));
      vt[v].hold = int'($urandom_range(1, 4));
      vt[v].exp_recs = int'(vt[v].n);
      vt[v].exp_cyc0 = vt[v].latc;
    end

    #12;
    chk("reset_outputs", {busy, done, error, res_valid, rsa_kgs, res_match, res_timeout}, 0);
    chk("reset_operands", {rsa_p, rsa_q, rsa_m, res_m, res_cycles}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      mode = vt[v].mode;
      latc = vt[v].latc;
      flip = vt[v].flip;
      hold = vt[v].hold;
      base = run_idx;
      rb = got.size();
      kb = kgs_at.size();
      d0 = done_cnt;
      go(vt[v].p, vt[v].q, vt[v].mf, vt[v].n, 1'b0);
      wait_done(1'b0, d0, "sweep_done");
      chk("n_records", got.size() - rb, vt[v].exp_recs);
      chk("n_keygen", kgs_at.size() - kb, vt[v].exp_recs);
      if (got.size() - rb == vt[v].exp_recs && kgs_at.size() - kb == vt[v].exp_recs) begin
        chk("start_to_keygen", kgs_at[kb] - start_cyc, 2);
        chk("first_cycles", got[rb].cycles, vt[v].exp_cyc0);
        lprev = 0;
        for (int i = 0; i < vt[v].exp_recs; i++) begin
          m_e = vt[v].mf + W'(i);
          r = got[rb + i];
          chk("rec_m", r.m, m_e);
          chk("rec_cycles", r.cycles, lat_of(m_e));
          chk("rec_match", r.match, (i != vt[v].flip) ? 1 : 0);
          chk("rec_timeout", r.timeout, 0);
          gap = lprev + ((hold + 1 > 3) ? hold + 1 : 3);
          if (i > 0) chk("keygen_gap", kgs_at[kb + i] - kgs_at[kb + i - 1], gap);
          lprev = lat_of(m_e);
        end
      end
      chk("sweep_idle", {busy, error}, 0);
    end

    // Sink stalls: record must hold still until accepted.
    mode = 0;
    latc = 10;
    hold = 1;
    flip = -1;
    base = run_idx;
    res_ready = 1'b0;
    d0 = done_cnt;
    go(8'd11, 8'd13, 8'd77, 8'd1, 1'b0);
    for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
    chk("stall_valid", res_valid, 1);
    snap = {res_m, res_cycles, res_match, res_timeout};
    chk("stall_record", snap, {8'd77, 16'd10, 1'b1, 1'b0});
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {res_valid, res_m, res_cycles, res_match, res_timeout}, {1'b1, snap});
    end
    res_ready = 1'b1;
    wait_done(1'b0, d0, "stall_done");
    chk("stall_idle", busy, 0);

    // Core never finishes: one timed-out record, sweep aborted.
    kb = kgs_t_cnt;
    rb = got_t.size();
    d0 = done_t_cnt;
    go(8'd11, 8'd13, 8'd5, 8'd3, 1'b1);
    wait_done(1'b1, d0, "tmo_done");
    chk("tmo_n_records", got_t.size() - rb, 1);
    if (got_t.size() - rb == 1) begin
      r = got_t[rb];
      chk("tmo_cycles", r.cycles, TMO_T);
      chk("tmo_flag", r.timeout, 1);
      chk("tmo_match", r.match, 0);
      chk("tmo_m", r.m, 5);
    end
    chk("tmo_error", error_t, 1);
    repeat (20) @(negedge clk);
    chk("tmo_no_relaunch", kgs_t_cnt - kb, 1);
    chk("tmo_idle", busy_t, 0);
    d0 = done_t_cnt;
    go(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    wait_done(1'b1, d0, "tmo_clear_done");
    chk("tmo_error_cleared", error_t, 0);

    // Empty sweep: done only, no launch, single-cycle pulse.
    kb = kgs_at.size();
    d0 = done_cnt;
    go(8'd1, 8'd1, 8'd1, 8'd0, 1'b0);
    wait_done(1'b0, d0, "empty_done");
    repeat (4) @(negedge clk);
    chk("empty_no_keygen", kgs_at.size() - kb, 0);
    chk("empty_one_done", done_cnt - d0, 1);

    // Reset in the middle of a run abandons it.
    latc = 50;
    base = run_idx;
    kb = kgs_at.size();
    rb = got.size();
    go(8'd11, 8'd13, 8'd33, 8'd2, 1'b0);
    for (int i = 0; i < 50 && kgs_at.size() == kb; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("midwait_busy", {busy, rsa_m}, {1'b1, 8'd33});
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_reset_outputs", {busy, done, error, res_valid, rsa_kgs, res_match, res_timeout}, 0);
    chk("midwait_reset_operands", {rsa_p, rsa_q, rsa_m, res_m, res_cycles}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("midwait_no_record", got.size() - rb, 0);
    chk("midwait_no_relaunch", kgs_at.size() - kb, 1);
    chk("midwait_idle", busy, 0);

    chk("stale_finish_at_launch", stale, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rsa_timing_probe.md
# rsa_timing_probe

Host-side driver and timing observer for the `RSA` core. It launches a sweep of plaintexts through the core's key-generation / encrypt / decrypt run and measures the clock cycles from `KeyGenStart` to `finish` for each run. It checks `m_decrypted` against the launched message and streams one result record per message to a logging sink. This is the measurement end of the timing side-channel experiment: it sits between the testbench/host and `RSA`, and owns every `RSA` input.

## Interface
Parameters:
- `WIDTH`, 8: operand width; must match `RSA`.
- `CNT_W`, 16: cycle-counter and `res_cycles` width.
- `TIMEOUT`, 16'd4000: cycle budget per run; must be ≤ 2^CNT_W−1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle sweep request; ignored while `busy`.
- `p_in`, `q_in`  in  WIDTH  primes; sampled on accepted `start`.
- `m_first`  in  WIDTH  first plaintext; sampled on accepted `start`.
- `num_msgs`  in  WIDTH  number of runs; sampled on accepted `start`.
- `rsa_p`, `rsa_q`, `rsa_m`  out  WIDTH  drive `RSA.p/q/m`.
- `rsa_KeyGenStart`  out  1  drives `RSA.KeyGenStart`.
- `rsa_m_decrypted`  in  WIDTH  from `RSA.m_decrypted`.
- `rsa_finish`  in  1  from `RSA.finish`.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  sink accepts record.
- `res_m`  out  WIDTH  launched plaintext.
- `res_cycles`  out  CNT_W  measured latency.
- `res_match`  out  1  `rsa_m_decrypted == res_m`.
- `res_timeout`  out  1  run exceeded `TIMEOUT`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at sweep end.
- `error`  out  1  sticky: sweep aborted on timeout; cleared by next accepted `start`.

## Operation
- States: IDLE, LAUNCH, WAIT, REPORT, DRAIN, DONE.
- **IDLE**
  - On `start` with `num_msgs != 0`: latch `p_in`, `q_in`, `m_first`, and `remaining = num_msgs`; go to DRAIN.
  - On `start` with `num_msgs == 0`: go straight to DONE with no runs.
- **DRAIN**: wait until `rsa_finish == 0`, then go to LAUNCH. This guarantees a stale level-`finish` is never counted.
- **LAUNCH** (one cycle): `rsa_KeyGenStart = 1`; counter cleared to 0; go to WAIT.
- **WAIT**: counter += 1 each cycle.
  - On `rsa_finish == 1`: capture `res_cycles = counter`, `res_m = rsa_m`, `res_match`; go to REPORT.
  - When counter reaches `TIMEOUT` without `finish`: `res_cycles = TIMEOUT`, `res_timeout = 1`, `res_match = 0`; set `error`; go to REPORT.
- **REPORT**: `res_valid = 1`; record held stable until `res_valid && res_ready`. Then:
  - If timed out, or `remaining == 1`: go to DONE.
  - Otherwise: `rsa_m += 1` (mod 2^WIDTH, wraps 255→0), `remaining -= 1`, go to DRAIN.
- **DONE**: `done = 1` for one cycle; go to IDLE.
- `rsa_p`, `rsa_q`, `rsa_m` are registered and held stable from LAUNCH until `rsa_finish` is sampled.
- `busy = 1` in every state except IDLE; `start` is ignored while busy.
- Counter saturates at `TIMEOUT`; it never wraps.

## Timing
- Reset (async, any state) values: state IDLE; all outputs 0; `rsa_*` operands 0; `rsa_KeyGenStart` 0.
  - A reset during WAIT abandons the run silently.
- Latency rule: `rsa_KeyGenStart` is high in cycle t and `rsa_finish` is first sampled high in cycle t+k → `res_cycles = k`.
- `start` accepted at edge e → `rsa_KeyGenStart` high no earlier than cycle e+2 (the DRAIN cycle comes first).
- `res_valid` is asserted the cycle after `finish` is sampled. With `res_ready` held high, back-to-back runs cost 3 cycles of overhead (REPORT, DRAIN, LAUNCH) plus k.
- `finish` and `res_ready` are both sampled at registered edges, so there is no combinational path from any input to `rsa_KeyGenStart`.

## Structure
- Shared package `rsa_pkg`: `WIDTH` default, probe state enum, result record struct (`m`, `cycles`, `match`, `timeout`).
- Sub-module `rsa_cycle_counter`: clear / enable / saturate-at-limit counter with `hit_limit` output. The FSM and operand registers stay in the top.

## Test plan
Bench uses a behavioural `RSA` stub with programmable latency per message.
- Stub latency 37, `p=11 q=13 m_first=5 num_msgs=1`, `res_ready=1` → one record: `m=5`, `cycles=37`, `match=1`, `timeout=0`; then `done` pulse; `busy` low.
- Latency = 20 + m, `m_first=254`, `num_msgs=4` → records with `m` = 254, 255, 0, 1 and cycles = 274, 275, 20, 21 (tests wrap).
- Stub returns `m^1` on the second run → that record has `match=0`; the others have 1; sweep completes.
- Stub never finishes, `TIMEOUT=100` → `cycles=100`, `timeout=1`, `error=1`, `done`; no further `KeyGenStart`.
- Stub holds `finish` high as a level for 3 cycles; `res_ready` low for 5 cycles → record held unchanged; next `KeyGenStart` only after `finish` falls.
- `rst_n` low mid-WAIT → outputs return to 0 the same cycle; `start` with `num_msgs=0` → `done` only, no `KeyGenStart`.
